wb_mem_slave: RTL and testbench

Wishbone classic-cycle responder that serves the core's data/instruction bus from an on-chip word array. It sits on the far side of the bus from the core's Wishbone initiator and decodes, wait-states, byte-merges and acknowledges each access. It raises a sticky test-done flag when software writes 1 to a mailbox word.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_mem_slave_if.sv | 35 +++
 rtl/wb_mem_array.sv | 34 +++
 rtl/wb_mem_slave.sv | 112 +++++++++++
 tb/tb_wb_mem_slave.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types, widths and the byte-lane merge helper for the Wishbone memory responder.
// Optional error response is enabled by WB_MEM_SLAVE_ERR_EN (see wb_mem_slave).
package wb_pkg;

  localparam int unsigned WB_DAT_W    = 32;
  localparam int unsigned WB_SEL_W    = 4;
  localparam int unsigned WB_MAX_WAIT = 15;
  localparam int unsigned WB_CNT_W    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } wb_slv_state_t;

  // Lanes with sel=1 take the new byte, the rest keep the stored byte.
  function automatic logic [WB_DAT_W-1:0] wb_merge(input logic [WB_DAT_W-1:0] old_word,
                                                   input logic [WB_DAT_W-1:0] new_word,
                                                   input logic [WB_SEL_W-1:0] sel);
    logic [WB_DAT_W-1:0] merged;
    for (int i = 0; i < int'(WB_SEL_W); i++) begin
      merged[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_mem_slave_if.sv
// Wishbone classic bus bundle between the core's initiator and the memory responder.
// o_wb_err exists only when WB_MEM_SLAVE_ERR_EN is defined.
interface wb_mem_slave_if;
  import wb_pkg::*;

  logic                i_wb_cyc;
  logic                i_wb_stb;
  logic                i_wb_we;
  logic [WB_SEL_W-1:0] i_wb_sel;
  logic [31:0]         i_wb_adr;
  logic [WB_DAT_W-1:0] i_wb_dat;
  logic [WB_DAT_W-1:0] o_wb_dat;
  logic                o_wb_ack;
`ifdef WB_MEM_SLAVE_ERR_EN
  logic                o_wb_err;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_adr, i_wb_dat,
    output o_wb_dat, o_wb_ack, o_wb_err
  );
  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_adr, i_wb_dat,
    input  o_wb_dat, o_wb_ack, o_wb_err
  );
`else
  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_adr, i_wb_dat,
    output o_wb_dat, o_wb_ack
  );
  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_adr, i_wb_dat,
    input  o_wb_dat, o_wb_ack
  );
`endif
endinterface

// File: rtl/wb_mem_array.sv
// 2^ADDR_WIDTH x 32 word array with byte-lane writes and a registered read port.
// The merged word is exposed so the caller can inspect what a write will store.
module wb_mem_array
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [WB_SEL_W-1:0]   i_sel,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [WB_DAT_W-1:0]   i_wdat,
  output logic [WB_DAT_W-1:0]   o_rdat,
  output logic [WB_DAT_W-1:0]   o_merged
);

  logic [WB_DAT_W-1:0] mem [2**ADDR_WIDTH];
  logic [WB_DAT_W-1:0] r_rdat;

  assign o_merged = wb_merge(mem[i_addr], i_wdat, i_sel);
  assign o_rdat   = r_rdat;

  // Read-first: a read captures the word as it stood before any same-edge write.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_addr] <= o_merged;
    end
    if (i_re) begin
      r_rdat <= mem[i_addr];
    end
  end

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone classic responder: wait-state FSM, byte-merged array access, test-done mailbox.
// Define WB_MEM_SLAVE_ERR_EN to answer out-of-range addresses with o_wb_err instead of aliasing.
module wb_mem_slave
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned DONE_WORD   = 320
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  wb_mem_slave_if.slave  bus,
  output logic           o_done
);

  localparam logic [WB_CNT_W-1:0]   WaitInit = WB_CNT_W'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] DoneIdx  = ADDR_WIDTH'(DONE_WORD);

  wb_slv_state_t         r_state, w_state_nxt;
  logic [WB_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic                  r_err, r_done;
  logic                  w_req, w_enter_ack, w_oor, w_commit, w_in_ack;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [WB_DAT_W-1:0]   w_rdat, w_merged;
  logic                  w_unused_adr;

  assign w_req        = bus.i_wb_cyc & bus.i_wb_stb;
  assign w_idx        = bus.i_wb_adr[ADDR_WIDTH+1:2];
  assign w_unused_adr = ^{bus.i_wb_adr[31:ADDR_WIDTH+2], bus.i_wb_adr[1:0]};

`ifdef WB_MEM_SLAVE_ERR_EN
  assign w_oor = |bus.i_wb_adr[31:ADDR_WIDTH+2];
`else
  assign w_oor = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_enter_ack = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          w_cnt_nxt = WaitInit;
          if (WAIT_STATES == 0) begin
            w_state_nxt = StAck;
            w_enter_ack = 1'b1;
          end else begin
            w_state_nxt = StWait;
          end
        end
      end
      StWait: begin
        // Master withdrawing the request aborts: no write, no ack.
        if (!w_req) begin
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == WB_CNT_W'(1)) begin
            w_state_nxt = StAck;
            w_enter_ack = 1'b1;
          end
        end
      end
      StAck:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // A write held off by reset is dropped; the array has no reset of its own.
  assign w_commit = w_enter_ack & bus.i_wb_we & ~w_oor & i_rst_n;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_enter_ack) begin
        r_err <= w_oor;
      end
      if (w_commit && (w_idx == DoneIdx)) begin
        r_done <= (w_merged == 32'h0000_0001);
      end
    end
  end

  wb_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .i_clk    (i_clk),
    .i_we     (w_commit),
    .i_re     (w_enter_ack),
    .i_sel    (bus.i_wb_sel),
    .i_addr   (w_idx),
    .i_wdat   (bus.i_wb_dat),
    .o_rdat   (w_rdat),
    .o_merged (w_merged)
  );

  assign w_in_ack     = (r_state == StAck);
  assign bus.o_wb_ack = w_in_ack & ~r_err;
  assign bus.o_wb_dat = (w_in_ack & ~r_err) ? w_rdat : '0;
`ifdef WB_MEM_SLAVE_ERR_EN
  assign bus.o_wb_err = w_in_ack & r_err;
`endif
  assign o_done       = r_done;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Scoreboard bench for wb_mem_slave: four instances at wait states 0/3/5/1 share one driven bus.
// Covers WB_MEM_SLAVE_ERR_EN when that macro is defined for the build.
module tb_wb_mem_slave;

  typedef struct {
    int          due;
    bit          rd;
    logic [31:0] dat;
    bit          cd;
    bit          done;
    bit          err;
    string       name;
  } exp_t;

  localparam int WS_TAB [4] = '{0, 3, 5, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat = '0;
  int          dsel = 0;
  int          cyc_cnt = 0;
  int          checks = 0, errors = 0, ack_total = 0;
  exp_t        sb[$];

  logic        ack_m, err_m, done_m;
  logic [31:0] dat_m;
  logic        done_v [4];

  wb_mem_slave_if if0 ();
  wb_mem_slave_if if1 ();
  wb_mem_slave_if if2 ();
  wb_mem_slave_if if3 ();

  assign if0.i_wb_cyc = cyc & (dsel == 0); assign if0.i_wb_stb = stb & (dsel == 0);
  assign if1.i_wb_cyc = cyc & (dsel == 1); assign if1.i_wb_stb = stb & (dsel == 1);
  assign if2.i_wb_cyc = cyc & (dsel == 2); assign if2.i_wb_stb = stb & (dsel == 2);
  assign if3.i_wb_cyc = cyc & (dsel == 3); assign if3.i_wb_stb = stb & (dsel == 3);
  assign if0.i_wb_we = we; assign if0.i_wb_sel = sel; assign if0.i_wb_adr = adr;
  assign if1.i_wb_we = we; assign if1.i_wb_sel = sel; assign if1.i_wb_adr = adr;
  assign if2.i_wb_we = we; assign if2.i_wb_sel = sel; assign if2.i_wb_adr = adr;
  assign if3.i_wb_we = we; assign if3.i_wb_sel = sel; assign if3.i_wb_adr = adr;
  assign if0.i_wb_dat = dat; assign if1.i_wb_dat = dat;
  assign if2.i_wb_dat = dat; assign if3.i_wb_dat = dat;

  wb_mem_slave #(.ADDR_WIDTH(9), .WAIT_STATES(0), .DONE_WORD(320)) u_d0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if0), .o_done(done_v[0]));
  wb_mem_slave #(.ADDR_WIDTH(9), .WAIT_STATES(3), .DONE_WORD(320)) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if1), .o_done(done_v[1]));
  wb_mem_slave #(.ADDR_WIDTH(9), .WAIT_STATES(5), .DONE_WORD(320)) u_d2 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if2), .o_done(done_v[2]));
  wb_mem_slave #(.ADDR_WIDTH(9), .WAIT_STATES(1), .DONE_WORD(320)) u_d3 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if3), .o_done(done_v[3]));

  always_comb begin
    ack_m  = 1'b0;
    err_m  = 1'b0;
    dat_m  = '0;
    done_m = 1'b0;
    case (dsel)
      0: begin ack_m = if0.o_wb_ack; dat_m = if0.o_wb_dat; done_m = done_v[0]; end
      1: begin ack_m = if1.o_wb_ack; dat_m = if1.o_wb_dat; done_m = done_v[1]; end
      2: begin ack_m = if2.o_wb_ack; dat_m = if2.o_wb_dat; done_m = done_v[2]; end
      default: begin ack_m = if3.o_wb_ack; dat_m = if3.o_wb_dat; done_m = done_v[3]; end
    endcase
`ifdef WB_MEM_SLAVE_ERR_EN
    case (dsel)
      0: err_m = if0.o_wb_err;
      1: err_m = if1.o_wb_err;
      2: err_m = if2.o_wb_err;
      default: err_m = if3.o_wb_err;
    endcase
`endif
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc_cnt);
    end
  endtask

  // Monitor: pops one expectation per response and checks timing, data, flags.
  initial begin : monitor
    exp_t e;
    bit   prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_m) begin
        ack_total++;
        chk("ack_not_adjacent", 32'(prev_ack), 32'd0);
      end
      if (!ack_m) chk("dat_zero_when_idle", dat_m, 32'h0);
      if (ack_m || err_m) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_response: got ack=%0b err=%0b, expected none", ack_m, err_m);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_cycle"}, 32'(cyc_cnt), 32'(e.due));
          chk({e.name, "_err"}, 32'(err_m), 32'(e.err));
          chk({e.name, "_ack"}, 32'(ack_m), 32'(!e.err));
          if (e.rd) chk({e.name, "_data"}, dat_m, e.dat);
          if (e.cd) chk({e.name, "_done"}, 32'(done_m), 32'(e.done));
        end
      end
      prev_ack = ack_m;
    end
  end

  task automatic wait_resp(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = ack_m | err_m;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: got no response, expected one within 40 cycles", nm);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the posedge that ends the response cycle.
  task automatic issue(input int d, input bit w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] wd, input bit rdc, input logic [31:0] xd,
                       input bit cd, input bit xdone, input bit xerr, input string nm);
    exp_t e;
    dsel = d; we = w; sel = s; adr = a; dat = wd; cyc = 1'b1; stb = 1'b1;
    e.due = cyc_cnt + WS_TAB[d] + 1; e.rd = rdc; e.dat = xd;
    e.cd = cd; e.done = xdone; e.err = xerr; e.name = nm;
    sb.push_back(e);
    wait_resp(nm);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] s, input bit cd, input bit xdone, input string nm);
    issue(d, 1'b1, s, a, wd, 1'b0, '0, cd, xdone, 1'b0, nm);
  endtask

  task automatic rd(input int d, input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] xd, input bit cd, input bit xdone, input string nm);
    issue(d, 1'b0, s, a, '0, 1'b1, xd, cd, xdone, 1'b0, nm);
  endtask

  initial begin : stim
    int base, t0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      dsel = d; #1;
      chk("reset_ack", 32'(ack_m), 32'd0);
      chk("reset_dat", dat_m, 32'h0);
      chk("reset_done", 32'(done_m), 32'd0);
    end
    u_d0.u_mem.mem[0]  = 32'h0BAD_F00D;
    u_d1.u_mem.mem[5]  = 32'h1234_5678;
    u_d2.u_mem.mem[7]  = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) u_d3.u_mem.mem[16+i] = 32'hA500_0000 + 32'(i) * 32'h1111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero wait states: write then read back through the decoded index 0x141.
    wr(0, 32'h0000_0504, 32'h0000_0015, 4'hF, 1'b1, 1'b0, "ws0_write");
    rd(0, 32'h0000_0504, 4'hF, 32'h0000_0015, 1'b0, 1'b0, "ws0_read");

    // Three wait states with a partial-lane write; read with sel=0 still returns the word.
    wr(1, 32'h0000_0014, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0, "ws3_write");
    rd(1, 32'h0000_0014, 4'h0, 32'h12BB_56DD, 1'b0, 1'b0, "ws3_read");
`ifndef WB_MEM_SLAVE_ERR_EN
    rd(1, 32'h8000_0017, 4'hF, 32'h12BB_56DD, 1'b0, 1'b0, "alias_read");
`endif

    // Abort a write after two cycles in WAIT.
    base = ack_total;
    dsel = 2; we = 1'b1; sel = 4'hF; adr = 32'h0000_001C; dat = 32'h1111_1111;
    cyc = 1'b1; stb = 1'b1;
    repeat (2) @(posedge clk);
    #1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_ack", 32'(ack_total - base), 32'd0);
    rd(2, 32'h0000_001C, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, "abort_read");
    wr(2, 32'h0000_001C, 32'h0000_0000, 4'h0, 1'b0, 1'b0, "sel0_write");
    rd(2, 32'h0000_001C, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, "sel0_read");

    // Mailbox set, clear, set, then a reset lands on a pending clearing write.
    wr(2, 32'h0000_0500, 32'h0000_0001, 4'hF, 1'b1, 1'b1, "mbox_set");
    wr(2, 32'h0000_0500, 32'h0000_0000, 4'hF, 1'b1, 1'b0, "mbox_clr");
    wr(2, 32'h0000_0500, 32'h0000_0001, 4'hF, 1'b1, 1'b1, "mbox_set2");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mbox_hold", 32'(done_m), 32'd1);
    @(posedge clk); #1;
    we = 1'b1; sel = 4'hF; adr = 32'h0000_0500; dat = 32'h0000_0002; cyc = 1'b1; stb = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ack", 32'(ack_m), 32'd0);
    chk("midrst_done", 32'(done_m), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(2, 32'h0000_0500, 4'hF, 32'h0000_0001, 1'b1, 1'b0, "midrst_read");

    // Stream of 8 reads with stb held high, one wait state.
    base = ack_total;
    dsel = 3; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    t0 = cyc_cnt;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      adr = 32'h0000_0040 + 32'(4 * i);
      e.due = t0 + 2 + 3 * i; e.rd = 1'b1; e.dat = 32'hA500_0000 + 32'(i) * 32'h1111;
      e.cd = 1'b0; e.done = 1'b0; e.err = 1'b0; e.name = "stream";
      sb.push_back(e);
      wait_resp("stream");
      @(posedge clk); #1;
    end
    cyc = 1'b0; stb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stream_ack_count", 32'(ack_total - base), 32'd8);

    // Out-of-range address: error response, or aliasing onto word 0.
`ifdef WB_MEM_SLAVE_ERR_EN
    issue(0, 1'b1, 4'hF, 32'h0000_1000, 32'hCAFE_0001, 1'b0, '0, 1'b0, 1'b0, 1'b1, "oor_write");
    rd(0, 32'h0000_0000, 4'hF, 32'h0BAD_F00D, 1'b0, 1'b0, "oor_word0");
`else
    wr(0, 32'h0000_1000, 32'hCAFE_0001, 4'hF, 1'b0, 1'b0, "oor_write");
    rd(0, 32'h0000_0000, 4'hF, 32'hCAFE_0001, 1'b0, 1'b0, "oor_word0");
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
